// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-port memory arbiter.
// Port 0 carries instruction fetches and port 1 carries data accesses.
package mem_arb_pkg;

  localparam int AW_DEF       = 16;
  localparam int DW_DEF       = 16;
  localparam int MAX_WAIT_DEF = 4;

  typedef enum logic {
    PORT_IFETCH = 1'b0,
    PORT_DATA   = 1'b1
  } port_e;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port single-memory arbiter. Port 1 (data) has priority, but port 0
// (fetch) is forced through once it has been denied MAX_WAIT times.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  localparam int AGE_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p0_req,
  input  logic             p0_we,
  input  logic [AW-1:0]    p0_addr,
  input  logic [DW-1:0]    p0_wdata,
  input  logic             p1_req,
  input  logic             p1_we,
  input  logic [AW-1:0]    p1_addr,
  input  logic [DW-1:0]    p1_wdata,
  output logic             p0_gnt,
  output logic             p1_gnt,
  output logic             p0_rvalid,
  output logic             p1_rvalid,
  output logic [DW-1:0]    p0_rdata,
  output logic [DW-1:0]    p1_rdata,
  output logic [AW-1:0]    mem_raddr,
  output logic             mem_re,
  output logic [AW-1:0]    mem_waddr,
  output logic [DW-1:0]    mem_wdata,
  output logic             mem_we,
  input  logic [DW-1:0]    mem_rdata,
  output logic [AGE_W-1:0] dbg_age_cnt
);

  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  logic [AGE_W-1:0] age_q, age_d;
  logic             rd_pend_q, rd_pend_d;
  port_e            rd_sel_q, rd_sel_d;

  logic             p0_win, p1_win, any_win, win_we;
  logic [AW-1:0]    win_addr;
  logic [DW-1:0]    win_wdata;

  // Grants are gated by rst so they drop the moment reset asserts.
  always_comb begin
    p0_win    = rst && p0_req && (!p1_req || (age_q == AGE_MAX));
    p1_win    = rst && p1_req && !p0_win;
    any_win   = p0_win || p1_win;
    win_we    = p0_win ? p0_we    : p1_we;
    win_addr  = p0_win ? p0_addr  : p1_addr;
    win_wdata = p0_win ? p0_wdata : p1_wdata;

    p0_gnt    = p0_win;
    p1_gnt    = p1_win;
    mem_re    = any_win && !win_we;
    mem_we    = any_win && win_we;
    mem_raddr = mem_re ? win_addr  : '0;
    mem_waddr = mem_we ? win_addr  : '0;
    mem_wdata = mem_we ? win_wdata : '0;

    age_d = age_q;
    if (p0_win) begin
      age_d = '0;
    end else if (rst && p0_req && (age_q != AGE_MAX)) begin
      age_d = age_q + AGE_W'(1);
    end

    rd_pend_d = mem_re;
    rd_sel_d  = p0_win ? PORT_IFETCH : PORT_DATA;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_sel_q  <= PORT_IFETCH;
    end else begin
      age_q     <= age_d;
      rd_pend_q <= rd_pend_d;
      rd_sel_q  <= rd_sel_d;
    end
  end

  // Both ports see the memory data; rvalid tells each whether it is theirs.
  assign p0_rvalid   = rd_pend_q && (rd_sel_q == PORT_IFETCH);
  assign p1_rvalid   = rd_pend_q && (rd_sel_q == PORT_DATA);
  assign p0_rdata    = mem_rdata;
  assign p1_rdata    = mem_rdata;
  assign dbg_age_cnt = age_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a memory stub preloaded with addr ^ 0x5A5A
// answers reads one cycle after mem_re; expected values are hand-computed.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk;
  logic        rst;
  mem_req_t    p0_r, p1_r;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [15:0] p0_rdata, p1_rdata;
  logic [15:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we;
  logic [2:0]  dbg_age_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:65535];

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_r.req), .p0_we(p0_r.we), .p0_addr(p0_r.addr), .p0_wdata(p0_r.wdata),
    .p1_req(p1_r.req), .p1_we(p1_r.we), .p1_addr(p1_r.addr), .p1_wdata(p1_r.wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_raddr(mem_raddr), .mem_re(mem_re),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .dbg_age_cnt(dbg_age_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    mem_rdata = '0;
  end

  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_raddr];
  end

  // Driver helpers
  function automatic mem_req_t rd(input logic [15:0] a);
    return '{req: 1'b1, we: 1'b0, addr: a, wdata: 16'h0};
  endfunction

  function automatic mem_req_t wr(input logic [15:0] a, input logic [15:0] d);
    return '{req: 1'b1, we: 1'b1, addr: a, wdata: d};
  endfunction

  function automatic mem_req_t idle();
    return '{req: 1'b0, we: 1'b0, addr: 16'h0, wdata: 16'h0};
  endfunction

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic step(input mem_req_t a, input mem_req_t b);
    @(negedge clk);
    p0_r = a;
    p1_r = b;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic exp_p0g [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [2:0] exp_age [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

  initial begin
    rst  = 1'b0;
    p0_r = rd(16'h0100);
    p1_r = rd(16'h0200);

    // Reset held with both ports requesting
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_p0_gnt", p0_gnt, 0);
    chk("rst_p1_gnt", p1_gnt, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_p0_rvalid", p0_rvalid, 0);
    chk("rst_p1_rvalid", p1_rvalid, 0);
    chk("rst_age", dbg_age_cnt, 0);
    chk("rst_raddr", mem_raddr, 0);

    // First grant right after release
    @(negedge clk);
    rst  = 1'b1;
    p0_r = idle();
    p1_r = rd(16'h0010);
    #1;
    chk("rel_p1_gnt", p1_gnt, 1);
    chk("rel_mem_re", mem_re, 1);
    chk("rel_raddr", mem_raddr, 16'h0010);
    chk("rel_mem_we", mem_we, 0);
    step(idle(), idle());
    chk("rel_p1_rvalid", p1_rvalid, 1);
    chk("rel_p1_rdata", p1_rdata, 16'h5A4A);
    chk("rel_p0_rvalid", p0_rvalid, 0);
    chk("idle_mem_re", mem_re, 0);

    // Contention: p1 wins four times, then p0 is forced through
    for (int i = 0; i < 6; i++) begin
      step(rd(16'h0100), rd(16'h0200));
      chk($sformatf("prio_p0_gnt_%0d", i), p0_gnt, exp_p0g[i]);
      chk($sformatf("prio_p1_gnt_%0d", i), p1_gnt, !exp_p0g[i]);
      chk($sformatf("prio_age_%0d", i), dbg_age_cnt, exp_age[i]);
      chk($sformatf("prio_raddr_%0d", i), mem_raddr, exp_p0g[i] ? 16'h0100 : 16'h0200);
      if (i > 0) begin
        chk($sformatf("prio_p0_rvalid_%0d", i), p0_rvalid, exp_p0g[i-1]);
        chk($sformatf("prio_p1_rvalid_%0d", i), p1_rvalid, !exp_p0g[i-1]);
        chk($sformatf("prio_rdata_%0d", i), p0_rdata, exp_p0g[i-1] ? 16'h5B5A : 16'h585A);
      end
    end
    step(idle(), idle());
    chk("prio_last_p1_rvalid", p1_rvalid, 1);
    chk("prio_last_rdata", p1_rdata, 16'h585A);
    chk("prio_age_after", dbg_age_cnt, 1);

    // Write then read of the same address
    step(idle(), wr(16'h0020, 16'hBEEF));
    chk("wr_p1_gnt", p1_gnt, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_re", mem_re, 0);
    chk("wr_waddr", mem_waddr, 16'h0020);
    chk("wr_wdata", mem_wdata, 16'hBEEF);
    chk("wr_age_hold", dbg_age_cnt, 1);
    step(rd(16'h0020), idle());
    chk("raw_p0_gnt", p0_gnt, 1);
    chk("raw_raddr", mem_raddr, 16'h0020);
    chk("raw_no_wr_rvalid", p1_rvalid, 0);
    step(idle(), idle());
    chk("raw_p0_rvalid", p0_rvalid, 1);
    chk("raw_p0_rdata", p0_rdata, 16'hBEEF);
    chk("raw_p1_rvalid", p1_rvalid, 0);
    chk("raw_age_clr", dbg_age_cnt, 0);

    // Alternating single reads, back to back
    step(rd(16'h0001), idle());
    chk("alt0_p0_gnt", p0_gnt, 1);
    step(idle(), rd(16'h0002));
    chk("alt1_p1_gnt", p1_gnt, 1);
    chk("alt1_p0_rvalid", p0_rvalid, 1);
    chk("alt1_p1_rvalid", p1_rvalid, 0);
    chk("alt1_rdata", p0_rdata, 16'h5A5B);
    step(rd(16'h0003), idle());
    chk("alt2_p0_gnt", p0_gnt, 1);
    chk("alt2_p1_rvalid", p1_rvalid, 1);
    chk("alt2_p0_rvalid", p0_rvalid, 0);
    chk("alt2_rdata", p1_rdata, 16'h5A58);
    step(idle(), idle());
    chk("alt3_p0_rvalid", p0_rvalid, 1);
    chk("alt3_p1_rvalid", p1_rvalid, 0);
    chk("alt3_rdata", p0_rdata, 16'h5A59);

    // Abandoned p0 request
    step(rd(16'h0003), rd(16'h0002));
    chk("ab0_p1_gnt", p1_gnt, 1);
    chk("ab0_p0_gnt", p0_gnt, 0);
    step(rd(16'h0003), rd(16'h0002));
    chk("ab1_p0_gnt", p0_gnt, 0);
    chk("ab1_age", dbg_age_cnt, 1);
    step(idle(), rd(16'h0002));
    chk("ab2_age", dbg_age_cnt, 2);
    chk("ab2_p0_gnt", p0_gnt, 0);
    step(idle(), idle());
    chk("ab3_age", dbg_age_cnt, 2);
    step(idle(), idle());
    chk("ab4_age", dbg_age_cnt, 2);
    chk("ab4_p0_rvalid", p0_rvalid, 0);

    // Reset pulsed while a p0 read is in flight
    step(rd(16'h0100), idle());
    chk("mr_p0_gnt", p0_gnt, 1);
    chk("mr_age_pre", dbg_age_cnt, 2);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_gnt_in_rst", p0_gnt, 0);
    chk("mr_re_in_rst", mem_re, 0);
    chk("mr_age_in_rst", dbg_age_cnt, 0);
    step(idle(), idle());
    rst = 1'b1;
    #1;
    chk("mr_p0_rvalid_a", p0_rvalid, 0);
    step(idle(), idle());
    chk("mr_p0_rvalid_b", p0_rvalid, 0);
    chk("mr_p1_rvalid_b", p1_rvalid, 0);
    chk("mr_age_post", dbg_age_cnt, 0);

    // Recovery after reset
    step(rd(16'h0200), idle());
    chk("rec_p0_gnt", p0_gnt, 1);
    step(idle(), idle());
    chk("rec_p0_rvalid", p0_rvalid, 1);
    chk("rec_rdata", p0_rdata, 16'h585A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 16, address width in bits.
REQ-002 Parameter DW, default 16, data width in bits.
REQ-003 Parameter MAX_WAIT, default 4, cycles port 0 may be denied before it is forced to win.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = in reset).
REQ-006 p0_req, p1_req  input  1 each  access request; held high until granted. Port 0 = instruction fetch, port 1 = data.
REQ-007 p0_we, p1_we  input  1 each  1 = write, 0 = read; valid while req is high.
REQ-008 p0_addr, p1_addr  input  AW each  access address.
REQ-009 p0_wdata, p1_wdata  input  DW each  write data.
REQ-010 p0_gnt, p1_gnt  output  1 each  combinational grant; the access is issued to memory in this cycle.
REQ-011 p0_rvalid, p1_rvalid  output  1 each  read data valid, registered.
REQ-012 p0_rdata, p1_rdata  output  DW each  read data; both driven from mem_rdata.
REQ-013 mem_raddr/mem_re, mem_waddr/mem_wdata/mem_we  output  AW/1, AW/DW/1  memory read and write ports.
REQ-014 mem_rdata  input  DW  memory read data, valid one cycle after mem_re is sampled.

Function
REQ-015 At most one access (read or write) is issued to memory per cycle, and at most one of p0_gnt and p1_gnt is high.
REQ-016 Arbitration rules:
- Only one port requesting: that port is granted.
- Both requesting: port 1 wins, unless age_cnt == MAX_WAIT, in which case port 0 wins.
REQ-017 age_cnt update:
- Increments, saturating at MAX_WAIT, each cycle p0_req is high and p0_gnt is low.
- Clears to 0 on any cycle p0_gnt is high.
- Holds otherwise.
REQ-018 Granted read: mem_re = 1 and mem_raddr = the winner's addr in the same cycle; mem_we = 0.
REQ-019 Granted write: mem_we = 1 with the winner's addr and wdata in the same cycle; mem_re = 0.
REQ-020 With no grant, mem_re and mem_we are 0; address and data outputs are don't-care but driven to 0.
REQ-021 Read return tracking: registers rd_pend and rd_sel capture (read granted, winner index) every cycle.
REQ-022 Read latency: pX_rvalid = rd_pend && rd_sel == X, i.e. exactly one cycle after the read's grant.
REQ-023 Writes never produce rvalid.
REQ-024 Back-to-back reads, from the same port or alternating ports, sustain one grant per cycle with no bubble.
REQ-025 A write on cycle N followed by a read of the same address on cycle N+1 returns the new data; ordering follows grant order.
REQ-026 A requester that deasserts req without being granted loses the request silently; age_cnt holds at its current value.

Reset
REQ-027 While rst = 0, all of the following are 0 immediately, without waiting for a clock edge: p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_re, mem_we, age_cnt, rd_pend, rd_sel.
REQ-028 A read granted in the cycle reset asserts is discarded; no rvalid follows after reset deasserts.
REQ-029 The first grant is possible in the first cycle after rst rises, with age_cnt starting at 0.

Structure
REQ-030 A shared package mem_arb_pkg holds:
- default AW, DW and MAX_WAIT constants;
- a port-index enum (PORT_IFETCH = 0, PORT_DATA = 1);
- a request struct {req, we, addr, wdata}.
REQ-031 The block is flat, with no sub-modules: grant logic is combinational; age_cnt, rd_pend and rd_sel are its only state.

Verification
REQ-032 Reset: hold rst = 0 with both ports requesting -> all outputs 0; release rst, port 1 reads 0x0010 -> p1_gnt and mem_re high with mem_raddr = 0x0010 in the same cycle, p1_rvalid high one cycle later.
REQ-033 Priority: both ports read continuously (p0 at 0x0100, p1 at 0x0200), MAX_WAIT = 4 -> p1 granted 4 cycles, p0 on cycle 5, then p1 again; age_cnt sequence 1,2,3,4,0.
REQ-034 Write-then-read: p1 writes 0xBEEF to 0x0020 on cycle N, p0 reads 0x0020 on cycle N+1 -> p0_rvalid at N+2 with p0_rdata = 0xBEEF, p1_rvalid stays low.
REQ-035 Routing: alternating single reads p0 (0x0001), p1 (0x0002), p0 (0x0003) on consecutive cycles -> rvalid pulses p0, p1, p0, each one cycle after its grant, no gaps, never both high.
REQ-036 Reset mid-read: p0 read granted, rst pulsed low before the next edge -> no p0_rvalid after release; age_cnt = 0.
REQ-037 Abandoned request: p0_req high 2 cycles while denied, then dropped -> no p0 grant; age_cnt holds 2 until p0 next wins.
